// File: rtl/spi_master_fifo_if.sv
// MMIO request/response bus for the SPI master: one-cycle request strobe, registered response one cycle later.
// No backpressure: every request is accepted and answered.
interface spi_master_fifo_if;
    logic        rq_en;
    logic [7:0]  rq_addr;
    logic        rq_iswrite;
    logic [31:0] rq_data;
    logic        rs_en;
    logic [31:0] rs_data;

    modport master (
        output rq_en, rq_addr, rq_iswrite, rq_data,
        input  rs_en, rs_data
    );

    modport slave (
        input  rq_en, rq_addr, rq_iswrite, rq_data,
        output rs_en, rs_data
    );
endinterface

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX byte FIFOs behind an MMIO register file; responses 1 cycle after each request.
// No bus backpressure: TX pushes when full and RX pops when empty are dropped; RX overflow is flagged.
module spi_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is still taken when a pop frees a slot in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_master_fifo #(
    parameter int NCS        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_master_fifo_if.slave bus,
    output logic             spi_clk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic [NCS-1:0]   spi_csn
);
    localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [DIV_W-1:0] sckdiv, div_l, hcnt;
    logic             cpha, cpol, cpha_l, cpol_l;
    logic [CSW-1:0]   csid, csid_l, cs_sel;
    logic             cs_on, cs_on_l, cs_en;
    logic             rx_ovf;
    logic [0:0]       state;
    logic [3:0]       ecnt;
    logic             sck_ph, mosi_q;
    logic [7:0]       tx_sh, rx_sh, rx_byte, tx_head, rx_head;
    logic [CW-1:0]    tx_count, rx_count;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             rd, wr, tx_push, tx_pop, rx_push, rx_pop;
    logic             busy, half_end, final_cyc, start, sample_now, shift_now;
    logic [31:0]      rd_data;

    assign rd      = bus.rq_en && !bus.rq_iswrite;
    assign wr      = bus.rq_en &&  bus.rq_iswrite;
    assign tx_push = wr && (bus.rq_addr == 8'h48);
    assign rx_pop  = rd && (bus.rq_addr == 8'h4C) && !rx_empty;

    assign busy       = (state == ST_BUSY);
    assign half_end   = busy && (hcnt == div_l);
    assign final_cyc  = half_end && (ecnt == 4'hF);
    // The final cycle of a frame can directly hand over to the next one.
    assign start      = (!busy || final_cyc) && !tx_empty;
    assign tx_pop     = start;
    // Even half-period ends are leading SCK edges; CPHA selects which edge samples.
    assign sample_now = half_end && (ecnt[0] == cpha_l);
    assign shift_now  = half_end && (ecnt[0] != cpha_l);
    assign rx_byte    = sample_now ? {rx_sh[6:0], spi_miso} : rx_sh;
    assign rx_push    = final_cyc;

    spi_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst_n(rst_n),
        .push(tx_push), .push_dat(bus.rq_data[7:0]),
        .pop(tx_pop), .pop_dat(tx_head),
        .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    spi_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst_n(rst_n),
        .push(rx_push), .push_dat(rx_byte),
        .pop(rx_pop), .pop_dat(rx_head),
        .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sckdiv <= DIV_W'(3);
            cpha   <= 1'b0;
            cpol   <= 1'b0;
            csid   <= '0;
            cs_on  <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (wr) begin
                case (bus.rq_addr)
                    8'h00: sckdiv <= bus.rq_data[DIV_W-1:0];
                    8'h04: {cpol, cpha} <= bus.rq_data[1:0];
                    8'h10: if (bus.rq_data < 32'(NCS)) csid <= bus.rq_data[CSW-1:0];
                    8'h18: cs_on <= bus.rq_data[1];
                    8'h50: if (bus.rq_data[31]) rx_ovf <= 1'b0;
                    default: ;
                endcase
            end
            if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            hcnt    <= '0;
            ecnt    <= '0;
            sck_ph  <= 1'b0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            mosi_q  <= 1'b0;
            div_l   <= DIV_W'(3);
            cpha_l  <= 1'b0;
            cpol_l  <= 1'b0;
            csid_l  <= '0;
            cs_on_l <= 1'b0;
        end else if (start) begin
            state   <= ST_BUSY;
            hcnt    <= '0;
            ecnt    <= '0;
            sck_ph  <= 1'b0;
            div_l   <= sckdiv;
            cpha_l  <= cpha;
            cpol_l  <= cpol;
            csid_l  <= csid;
            cs_on_l <= cs_on;
            mosi_q  <= tx_head[7];
            // CPHA=1 re-drives bit 7 on the first leading edge, so keep it in the shifter.
            tx_sh   <= cpha ? tx_head : {tx_head[6:0], 1'b0};
            rx_sh   <= '0;
        end else if (busy) begin
            if (final_cyc) state <= ST_IDLE;
            if (half_end) begin
                hcnt   <= '0;
                ecnt   <= ecnt + 4'd1;
                sck_ph <= ~sck_ph;
            end else begin
                hcnt   <= hcnt + DIV_W'(1);
            end
            if (shift_now) begin
                mosi_q <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (sample_now) rx_sh <= rx_byte;
        end
    end

    assign spi_clk  = busy ? (cpol_l ^ sck_ph) : cpol;
    assign spi_mosi = mosi_q;
    assign cs_sel   = busy ? csid_l  : csid;
    assign cs_en    = busy ? cs_on_l : cs_on;

    always_comb begin
        spi_csn = '1;
        for (int i = 0; i < NCS; i++) begin
            if (cs_en && (cs_sel == CSW'(i))) spi_csn[i] = 1'b0;
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (bus.rq_addr)
            8'h00: rd_data = 32'(sckdiv);
            8'h04: rd_data = {30'h0, cpol, cpha};
            8'h10: rd_data = 32'(csid);
            8'h18: rd_data = {30'h0, cs_on, 1'b0};
            8'h48: rd_data = {tx_full, 31'h0};
            8'h4C: rd_data = rx_empty ? 32'h8000_0000 : {24'h0, rx_head};
            8'h50: rd_data = {rx_ovf, 14'h0, busy, 8'(rx_count), 8'(tx_count)};
            default: rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rs_en   <= 1'b0;
            bus.rs_data <= 32'h0;
        end else begin
            bus.rs_en   <= bus.rq_en;
            bus.rs_data <= rd ? rd_data : 32'h0;
        end
    end
endmodule
